// File: rtl/windowed_edge_rate_ctr_pkg.sv
// Shared definitions for the windowed edge-rate counter: edge-mode encodings
// and the derivation of the running-sum width.
package windowed_edge_rate_ctr_pkg;

    // Encoding of the EDGE_MODE input.
    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_mode_e;

    // N_SUB slots of at most 2**w-1 each sum to less than 2**(w+log2_n), so the
    // running sum never overflows at this width.
    function automatic int unsigned calc_sum_width(input int unsigned subctr_width,
                                                   input int unsigned log2_n_sub);
        return subctr_width + log2_n_sub;
    endfunction

endpackage

// File: rtl/windowed_edge_rate_ctr_edge_sync_detect.sv
// Brings the asynchronous encoder pulse into the CLK domain and produces a
// one-cycle edge pulse according to the selected edge mode.
module windowed_edge_rate_ctr_edge_sync_detect
    import windowed_edge_rate_ctr_pkg::*;
(
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       INC,
    input  logic [1:0] EDGE_MODE,
    output logic       EDGE
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Two-flop synchroniser followed by a one-cycle history register.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= INC;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Compare the synchronised level with its history per the edge mode.
    always_comb begin
        EDGE = 1'b0;
        unique case (edge_mode_e'(EDGE_MODE))
            EDGE_RISE: EDGE = sync2_q & ~prev_q;
            EDGE_FALL: EDGE = ~sync2_q & prev_q;
            EDGE_BOTH: EDGE = sync2_q ^ prev_q;
            EDGE_OFF:  EDGE = 1'b0;
        endcase
    end

endmodule

// File: rtl/windowed_edge_rate_ctr.sv
// Windowed edge-rate counter: counts qualified encoder edges per timed slot,
// keeps the last N_SUB slot counts in a ring and maintains their sum
// incrementally (add newest, subtract evicted) for the speed/PID path.
module windowed_edge_rate_ctr
    import windowed_edge_rate_ctr_pkg::*;
#(
    parameter int unsigned SUBCTR_WIDTH    = 8,
    parameter int unsigned LOG2_N_SUB_CTRS = 4,
    parameter int unsigned PERIOD_WIDTH    = 16,
    parameter int unsigned SUM_WIDTH       = calc_sum_width(SUBCTR_WIDTH, LOG2_N_SUB_CTRS)
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic                    INC,
    input  logic [1:0]              EDGE_MODE,
    input  logic [PERIOD_WIDTH-1:0] PERIOD,
    input  logic                    CLR,
    output logic [SUM_WIDTH-1:0]    SUM,
    output logic                    SUM_VALID,
    output logic                    SUM_UPD,
    output logic                    SAT
);

    localparam int unsigned N_SUB = 2 ** LOG2_N_SUB_CTRS;
    localparam logic [SUBCTR_WIDTH-1:0]    SUB_MAX   = '1;
    localparam logic [LOG2_N_SUB_CTRS:0]   FILL_FULL = (LOG2_N_SUB_CTRS + 1)'(N_SUB);
    localparam logic [LOG2_N_SUB_CTRS:0]   FILL_LAST = (LOG2_N_SUB_CTRS + 1)'(N_SUB - 1);
    localparam logic [LOG2_N_SUB_CTRS:0]   FILL_ONE  = (LOG2_N_SUB_CTRS + 1)'(1);
    localparam logic [LOG2_N_SUB_CTRS-1:0] PTR_ONE   = LOG2_N_SUB_CTRS'(1);
    localparam logic [PERIOD_WIDTH-1:0]    PER_ONE   = PERIOD_WIDTH'(1);

    logic                       edge_pulse;
    logic [PERIOD_WIDTH-1:0]    timer_q;
    logic [PERIOD_WIDTH-1:0]    period_last;
    logic                       boundary;
    logic [SUBCTR_WIDTH-1:0]    working_q;
    logic [SUBCTR_WIDTH-1:0]    slot_next;
    logic                       slot_ovf;
    logic [SUBCTR_WIDTH-1:0]    ring_q [N_SUB];
    logic [LOG2_N_SUB_CTRS-1:0] wr_ptr_q;
    logic [LOG2_N_SUB_CTRS:0]   fill_q;
    logic [SUM_WIDTH-1:0]       sum_q;
    logic [SUM_WIDTH-1:0]       sum_next;
    logic                       valid_q;
    logic                       upd_q;
    logic                       sat_q;

    windowed_edge_rate_ctr_edge_sync_detect u_edge (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .INC       (INC),
        .EDGE_MODE (EDGE_MODE),
        .EDGE      (edge_pulse)
    );

    // Slot-boundary decode, saturating slot count and next running sum.
    always_comb begin
        // PERIOD of 0 behaves as 1, i.e. a boundary every cycle.
        period_last = (PERIOD == '0) ? '0 : PERIOD - PER_ONE;
        // >= lets a runtime decrease of PERIOD close the current slot at once.
        boundary    = (timer_q >= period_last);
        slot_ovf    = edge_pulse & (working_q == SUB_MAX);
        slot_next   = slot_ovf ? SUB_MAX : working_q + SUBCTR_WIDTH'(edge_pulse);
        // Ring read is read-before-write: this is the slot being evicted.
        sum_next    = sum_q - SUM_WIDTH'(ring_q[wr_ptr_q]) + SUM_WIDTH'(slot_next);
    end

    // Slot timer, working counter, ring, running sum and output flags.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            timer_q   <= '0;
            working_q <= '0;
            ring_q    <= '{default: '0};
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            sum_q     <= '0;
            valid_q   <= 1'b0;
            upd_q     <= 1'b0;
            sat_q     <= 1'b0;
        end else if (CLR) begin
            // CLR wins over a coincident boundary; nothing is committed.
            timer_q   <= '0;
            working_q <= '0;
            ring_q    <= '{default: '0};
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            sum_q     <= '0;
            valid_q   <= 1'b0;
            upd_q     <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            upd_q <= boundary;
            if (slot_ovf) begin
                sat_q <= 1'b1;
            end
            if (boundary) begin
                // An edge on the boundary cycle belongs to the closing slot.
                timer_q          <= '0;
                working_q        <= '0;
                ring_q[wr_ptr_q] <= slot_next;
                wr_ptr_q         <= wr_ptr_q + PTR_ONE;
                sum_q            <= sum_next;
                if (fill_q != FILL_FULL) begin
                    fill_q <= fill_q + FILL_ONE;
                end
                if (fill_q == FILL_LAST) begin
                    valid_q <= 1'b1;
                end
            end else begin
                timer_q   <= timer_q + PER_ONE;
                working_q <= slot_next;
            end
        end
    end

    assign SUM       = sum_q;
    assign SUM_VALID = valid_q;
    assign SUM_UPD   = upd_q;
    assign SAT       = sat_q;

`ifndef SYNTHESIS
    logic [SUM_WIDTH-1:0] ring_total;

    // Debug cross-check: the incremental sum must equal the ring contents.
    always_comb begin
        ring_total = '0;
        foreach (ring_q[i]) begin
            ring_total = ring_total + SUM_WIDTH'(ring_q[i]);
        end
    end

    sum_matches_ring: assert property (@(posedge CLK) disable iff (!RESETN)
                                       sum_q == ring_total);
`endif

endmodule
